// File: rtl/nco_pkg.sv
// Shared NCO constants, quadrant encoding and the quarter-wave table generator.
// Latency constant only; no handshake.
package nco_pkg;

    localparam int NCO_LAT = 4;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

    // round(A*sin(2*pi*k/2^(raw+2))) for k in 0..2^raw; the end points are pinned so the
    // table hits 0 and A exactly regardless of floating-point error.
    function automatic int qw_amp(input int k, input int raw, input int mpr);
        real amp;
        real ang;
        amp = real'((1 << (mpr - 1)) - 1);
        if (k <= 0) return 0;
        if (k >= (1 << raw)) return (1 << (mpr - 1)) - 1;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << (raw + 2));
        return int'($floor(amp * $sin(ang) + 0.5));
    endfunction

endpackage

// File: rtl/nco_tdm_sincos_if.sv
// Config/commit strobes and sample output bus of the TDM sin/cos NCO.
// Output valid is a level; there is no backpressure.
interface nco_tdm_sincos_if #(
    parameter int APR = 32,
    parameter int MPR = 16,
    parameter int CW  = 2
);
    logic                  clken;
    logic                  cfg_wr;
    logic [CW-1:0]         cfg_ch;
    logic                  cfg_sel;
    logic [APR-1:0]        cfg_data;
    logic                  commit;
    logic                  commit_clr;
    logic                  commit_pend;
    logic signed [MPR-1:0] sin_o;
    logic signed [MPR-1:0] cos_o;
    logic [CW-1:0]         ch_o;
    logic                  out_valid;

    modport master (
        output clken, cfg_wr, cfg_ch, cfg_sel, cfg_data, commit, commit_clr,
        input  commit_pend, sin_o, cos_o, ch_o, out_valid
    );

    modport slave (
        input  clken, cfg_wr, cfg_ch, cfg_sel, cfg_data, commit, commit_clr,
        output commit_pend, sin_o, cos_o, ch_o, out_valid
    );
endinterface

// File: rtl/nco_qw_rom.sv
// Dual-read quarter-wave sine ROM, 2^RAW+1 unsigned entries built at elaboration.
// Latency 1 enabled cycle; en low holds the read registers, no backpressure.
module nco_qw_rom
    import nco_pkg::*;
#(
    parameter int RAW = 10,
    parameter int MPR = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic [RAW:0]   addr_a,
    input  logic [RAW:0]   addr_b,
    output logic [MPR-2:0] dat_a,
    output logic [MPR-2:0] dat_b
);
    localparam int DEPTH = (1 << RAW) + 1;

    logic [MPR-2:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = (MPR-1)'(qw_amp(k, RAW, MPR));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dat_a <= '0;
            dat_b <= '0;
        end else if (en) begin
            dat_a <= rom[addr_a];
            dat_b <= rom[addr_b];
        end
    end
endmodule

// File: rtl/nco_tdm_sincos.sv
// Time-multiplexed NCO: NC channels share one accumulator/table path, one channel per enabled cycle.
// Latency 4 enabled cycles accumulate-to-output; clken low freezes everything, no backpressure.
module nco_tdm_sincos
    import nco_pkg::*;
#(
    parameter int APR = 32,
    parameter int MPR = 16,
    parameter int RAW = 10,
    parameter int NC  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    nco_tdm_sincos_if.slave bus
);
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [RAW:0] QTR = (RAW+1)'(1) << RAW;

    logic [APR-1:0] acc     [NC];
    logic [APR-1:0] inc_act [NC];
    logic [APR-1:0] off_act [NC];
    logic [APR-1:0] inc_sh  [NC];
    logic [APR-1:0] off_sh  [NC];

    logic [CW-1:0]  ch;
    logic           pend;
    logic           clr_lat;

    logic           apply;
    logic           clr_now;
    logic           cfg_ok;
    logic [APR-1:0] base;
    logic [APR-1:0] off_cur;
    logic [APR-1:0] inc_cur;
    logic [APR-1:0] phase;
    logic           phase_lo_unused;

    // Apply uses the shadows directly so the boundary sample already sees the new values.
    always_comb begin
        apply   = bus.clken && (ch == '0) && (pend || bus.commit);
        clr_now = apply && (pend ? clr_lat : bus.commit_clr);
        base    = clr_now ? '0 : acc[ch];
        off_cur = apply ? off_sh[ch] : off_act[ch];
        inc_cur = apply ? inc_sh[ch] : inc_act[ch];
        phase   = base + off_cur;
    end

    assign phase_lo_unused = ^phase[APR-RAW-3:0];
    assign cfg_ok          = bus.cfg_wr && ({1'b0, bus.cfg_ch} < (CW+1)'(NC));
    assign bus.commit_pend = pend;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NC; i++) begin
                inc_sh[i] <= '0;
                off_sh[i] <= '0;
            end
        end else if (cfg_ok) begin
            if (bus.cfg_sel) off_sh[bus.cfg_ch] <= bus.cfg_data;
            else             inc_sh[bus.cfg_ch] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NC; i++) begin
                acc[i]     <= '0;
                inc_act[i] <= '0;
                off_act[i] <= '0;
            end
            ch <= '0;
        end else if (bus.clken) begin
            if (apply) begin
                for (int i = 0; i < NC; i++) begin
                    inc_act[i] <= inc_sh[i];
                    off_act[i] <= off_sh[i];
                    if (clr_now) acc[i] <= '0;
                end
            end
            acc[ch] <= base + inc_cur;
            ch      <= (ch == CW'(NC - 1)) ? '0 : ch + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend    <= 1'b0;
            clr_lat <= 1'b0;
        end else if (bus.clken) begin
            if (apply) begin
                pend    <= 1'b0;
                clr_lat <= 1'b0;
            end else if (bus.commit && !pend) begin
                pend    <= 1'b1;
                clr_lat <= bus.commit_clr;
            end
        end
    end

    // Stage 1: phase register.
    logic [RAW+1:0] s1_p;
    logic [CW-1:0]  s1_ch;
    logic           s1_vld;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_p   <= '0;
            s1_ch  <= '0;
            s1_vld <= 1'b0;
        end else if (bus.clken) begin
            s1_p   <= phase[APR-1 -: RAW+2];
            s1_ch  <= ch;
            s1_vld <= 1'b1;
        end
    end

    // Returns {negate, table address}; odd quadrants walk the table backwards.
    function automatic logic [RAW+1:0] fold(input logic [RAW+1:0] pp);
        quad_t      q;
        logic [RAW:0] a;
        q = quad_t'(pp[RAW+1:RAW]);
        a = {1'b0, pp[RAW-1:0]};
        case (q)
            Q0:      return {1'b0, a};
            Q1:      return {1'b0, QTR - a};
            Q2:      return {1'b1, a};
            default: return {1'b1, QTR - a};
        endcase
    endfunction

    logic [RAW+1:0] p_cos;
    logic [RAW+1:0] f_sin;
    logic [RAW+1:0] f_cos;

    assign p_cos = s1_p + {2'b01, {RAW{1'b0}}};
    assign f_sin = fold(s1_p);
    assign f_cos = fold(p_cos);

    // Stage 2: quadrant fold.
    logic [RAW:0]  s2_sin_addr;
    logic [RAW:0]  s2_cos_addr;
    logic          s2_sin_neg;
    logic          s2_cos_neg;
    logic [CW-1:0] s2_ch;
    logic          s2_vld;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_sin_addr <= '0;
            s2_cos_addr <= '0;
            s2_sin_neg  <= 1'b0;
            s2_cos_neg  <= 1'b0;
            s2_ch       <= '0;
            s2_vld      <= 1'b0;
        end else if (bus.clken) begin
            s2_sin_addr <= f_sin[RAW:0];
            s2_cos_addr <= f_cos[RAW:0];
            s2_sin_neg  <= f_sin[RAW+1];
            s2_cos_neg  <= f_cos[RAW+1];
            s2_ch       <= s1_ch;
            s2_vld      <= s1_vld;
        end
    end

    // Stage 3: table read, side data delayed alongside.
    logic [MPR-2:0] rom_sin;
    logic [MPR-2:0] rom_cos;
    logic           s3_sin_neg;
    logic           s3_cos_neg;
    logic [CW-1:0]  s3_ch;
    logic           s3_vld;

    nco_qw_rom #(.RAW(RAW), .MPR(MPR)) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (bus.clken),
        .addr_a  (s2_sin_addr),
        .addr_b  (s2_cos_addr),
        .dat_a   (rom_sin),
        .dat_b   (rom_cos)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s3_sin_neg <= 1'b0;
            s3_cos_neg <= 1'b0;
            s3_ch      <= '0;
            s3_vld     <= 1'b0;
        end else if (bus.clken) begin
            s3_sin_neg <= s2_sin_neg;
            s3_cos_neg <= s2_cos_neg;
            s3_ch      <= s2_ch;
            s3_vld     <= s2_vld;
        end
    end

    // Stage 4: sign and output register.
    logic signed [MPR-1:0] sin_mag;
    logic signed [MPR-1:0] cos_mag;

    assign sin_mag = $signed({1'b0, rom_sin});
    assign cos_mag = $signed({1'b0, rom_cos});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.sin_o     <= '0;
            bus.cos_o     <= '0;
            bus.ch_o      <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.clken) begin
            bus.sin_o     <= s3_sin_neg ? -sin_mag : sin_mag;
            bus.cos_o     <= s3_cos_neg ? -cos_mag : cos_mag;
            bus.ch_o      <= s3_ch;
            bus.out_valid <= s3_vld;
        end
    end
endmodule

// File: tb/tb_nco_tdm_sincos.sv
// Directed bench for the 4-channel TDM sin/cos NCO with hand-computed samples.
module tb_nco_tdm_sincos;
    logic clk = 1'b0;
    logic reset_n;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    localparam int A = 32767;
    localparam int H = 23170;

    always #5 clk = ~clk;

    nco_tdm_sincos_if #(.APR(32), .MPR(16), .CW(2)) bus ();

    nco_tdm_sincos #(.APR(32), .MPR(16), .RAW(10), .NC(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // cyc counts enabled edges since reset release, so cyc%4 is the channel the next edge samples.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (reset_n && bus.clken) cyc++;
            #1;
        end
    endtask

    task automatic align();
        for (int i = 0; i < 4; i++)
            if (cyc % 4 != 0) tick(1);
    endtask

    task automatic chk_out(input string tag, input int c, input int s, input int co);
        chk({tag, ".ch"},  64'(bus.ch_o), 64'(c));
        chk({tag, ".sin"}, bus.sin_o, 64'(s));
        chk({tag, ".cos"}, bus.cos_o, 64'(co));
    endtask

    int exp_s[4] = '{0, A, 0, -A};
    int exp_c[4] = '{A, 0, -A, 0};

    initial begin
        reset_n        = 1'b0;
        bus.clken      = 1'b1;
        bus.cfg_wr     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_sel    = 1'b0;
        bus.cfg_data   = '0;
        bus.commit     = 1'b0;
        bus.commit_clr = 1'b0;
        tick(2);
        chk("rst.valid", 64'(bus.out_valid), 0);
        chk("rst.pend",  64'(bus.commit_pend), 0);
        chk_out("rst", 0, 0, 0);

        // Release: valid after the 4th enabled edge, channels in order.
        reset_n = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk("rel.valid", 64'(bus.out_valid), 64'(k >= 4));
            if (k >= 4) chk_out("rel", (k - 4) % 4, 0, A);
        end

        // Quarter-turn increment on ch0.
        align();
        bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_sel = 1'b0; bus.cfg_data = 32'h4000_0000;
        tick(1);
        bus.cfg_wr = 1'b0;
        bus.commit = 1'b1; bus.commit_clr = 1'b1;
        tick(1);
        bus.commit = 1'b0; bus.commit_clr = 1'b0;
        chk("inc.pend1", 64'(bus.commit_pend), 1);
        tick(2);
        chk("inc.pend2", 64'(bus.commit_pend), 1);
        tick(1);
        chk("inc.pend3", 64'(bus.commit_pend), 0);
        tick(3);
        for (int j = 0; j < 8; j++) begin
            chk_out("inc", 0, exp_s[j % 4], exp_c[j % 4]);
            tick(4);
        end

        // Eighth-turn offset on ch2 with clearing commit.
        align();
        bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_sel = 1'b1; bus.cfg_data = 32'h2000_0000;
        tick(1);
        bus.cfg_wr = 1'b0;
        bus.commit = 1'b1; bus.commit_clr = 1'b1;
        tick(1);
        bus.commit = 1'b0; bus.commit_clr = 1'b0;
        chk("off.pend1", 64'(bus.commit_pend), 1);
        tick(2);
        chk("off.pend2", 64'(bus.commit_pend), 1);
        tick(1);
        chk("off.pend3", 64'(bus.commit_pend), 0);
        tick(3);
        chk_out("clr.ch0", 0, 0, A);
        tick(2);
        chk_out("off.ch2a", 2, H, H);
        tick(4);
        chk_out("off.ch2b", 2, H, H);

        // Same-cycle commit applies at once; the cfg_wr beside it waits for the next commit.
        align();
        bus.commit = 1'b1;
        bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_sel = 1'b1; bus.cfg_data = 32'h4000_0000;
        tick(1);
        bus.commit = 1'b0; bus.cfg_wr = 1'b0;
        chk("late.pend", 64'(bus.commit_pend), 0);
        tick(4);
        chk_out("late.ch1a", 1, 0, A);
        tick(4);
        chk_out("late.ch1b", 1, 0, A);
        align();
        bus.commit = 1'b1;
        tick(1);
        bus.commit = 1'b0;
        tick(4);
        chk_out("late.ch1c", 1, A, 0);

        // Clock-enable gaps: outputs hold, sequence resumes.
        bus.clken = 1'b0;
        tick(3);
        chk_out("hold", 1, A, 0);
        chk("hold.valid", 64'(bus.out_valid), 1);
        bus.clken = 1'b1;
        tick(1);
        chk_out("gap.ch2", 2, H, H);
        bus.clken = 1'b0; tick(1);
        bus.clken = 1'b1; tick(1);
        chk_out("gap.ch3", 3, 0, A);
        bus.clken = 1'b0; tick(2);
        chk("gap.valid", 64'(bus.out_valid), 1);
        bus.clken = 1'b1; tick(1);
        chk("gap.ch0", 64'(bus.ch_o), 0);
        tick(1);
        chk_out("gap.ch1", 1, A, 0);

        // One-cycle reset while a commit is pending.
        align();
        tick(1);
        bus.commit = 1'b1;
        tick(1);
        bus.commit = 1'b0;
        chk("rr.pend1", 64'(bus.commit_pend), 1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        cyc = 0;
        chk("rr.valid0", 64'(bus.out_valid), 0);
        chk("rr.pend0",  64'(bus.commit_pend), 0);
        chk_out("rr0", 0, 0, 0);
        tick(4);
        chk("rr.valid1", 64'(bus.out_valid), 1);
        chk("rr.pend2",  64'(bus.commit_pend), 0);
        chk_out("rr1", 0, 0, A);
        tick(1);
        chk_out("rr.ch1", 1, 0, A);
        tick(1);
        chk_out("rr.ch2", 2, 0, A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/nco_tdm_sincos.md
NCO_TDM_SINCOS -- requirements
Module: nco_tdm_sincos

Interface
REQ-001 Parameter APR, default 32, phase accumulator width in bits.
REQ-002 Parameter MPR, default 16, signed output width in bits.
REQ-003 Parameter RAW, default 10, quarter-wave ROM address width in bits.
REQ-004 Parameter NC, default 4, channel count; legal range 1..16; CW = max(1, clog2(NC)).
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 reset_n  in  1  reset, synchronous and active-low.
REQ-007 clken  in  1  global enable; low freezes all state, outputs hold.
REQ-008 cfg_wr  in  1  write strobe to shadow registers; ignores clken.
REQ-009 cfg_ch  in  CW  target channel of the write.
REQ-010 cfg_sel  in  1  write target: 0 = frequency increment, 1 = phase offset.
REQ-011 cfg_data  in  APR  write data.
REQ-012 commit  in  1  request to apply shadows at the next frame boundary.
REQ-013 commit_clr  in  1  sampled with commit; also zero all accumulators at apply.
REQ-014 commit_pend  out  1  commit accepted, not yet applied.
REQ-015 sin_o / cos_o  out  MPR each  signed sine and cosine samples.
REQ-016 ch_o  out  CW  channel of the current output sample.
REQ-017 out_valid  out  1  sin_o/cos_o/ch_o are valid.

Function
REQ-018 Channel counter ch advances 0..NC-1 and wraps, once per clken-high cycle; ch = 0 is the frame boundary.
REQ-019 Each enabled cycle: phase = acc[ch] + off[ch], then acc[ch] <= acc[ch] + inc[ch]; both are modulo 2^APR.
REQ-020 The first sample of a channel after reset or a clearing commit carries phase = off[ch].
REQ-021 Let p = phase[APR-1:APR-RAW-2] and A = 2^(MPR-1)-1.
REQ-022 sin_o = round(A*sin(2*pi*p/2^(RAW+2))) and cos_o = round(A*cos(...)), with bit-exact results at p = 0, 2^RAW, 2*2^RAW and 3*2^RAW.
REQ-023 The table is a quarter wave with 2^RAW+1 entries: quadrant bits p[RAW+1:RAW] select mirroring (addr' = 2^RAW - addr) and negation.
REQ-024 Cosine is produced from the same table at p + 2^RAW.
REQ-025 The pipeline has 4 stages: 1 phase/accumulate, 2 quadrant fold/address, 3 ROM read, 4 sign/register.
REQ-026 Latency is exactly 4 clken-high cycles from the accumulate cycle to the output; ch_o travels with the data.
REQ-027 out_valid rises on the 4th enabled cycle after reset release, then stays high until reset; clken low does not clear it.
REQ-028 A cfg_wr writes shadow inc[cfg_ch] or off[cfg_ch]; active values are unchanged until apply. If cfg_ch >= NC, the write is ignored.
REQ-029 commit while commit_pend = 0 sets commit_pend and latches commit_clr; commit while commit_pend = 1 is ignored.
REQ-030 Apply occurs on the first enabled cycle with ch = 0 and commit_pend = 1, including a commit arriving in that same cycle.
REQ-031 At apply: all active inc/off take their shadow values; if the latched clr = 1, all acc are set to 0; commit_pend is cleared.
REQ-032 The apply cycle's own sample uses the new active values and the cleared acc.
REQ-033 A cfg_wr in the apply cycle updates the shadow only; it is not included in that apply.
REQ-034 With NC = 1, every enabled cycle is a frame boundary.

Reset
REQ-035 When reset_n = 0 at a rising edge, all of the following SHALL be cleared to 0: acc, active and shadow inc/off, ch, pipeline registers, sin_o, cos_o, ch_o, out_valid, commit_pend.
REQ-036 Reset mid-frame or with a commit pending discards all state; no apply occurs after release.

Structure
REQ-037 Package nco_pkg SHALL hold the latency constant NCO_LAT = 4, a quadrant enum (Q0..Q3), and the table amplitude/rounding function used to initialise the ROM.
REQ-038 Sub-module nco_qw_rom SHALL be the dual-read synchronous quarter-wave ROM (2^RAW+1 x (MPR-1) unsigned), initialised from the nco_pkg function; no external hex file.
REQ-039 Per-channel registers SHALL be arrays indexed by ch; there are no per-channel instances.

Verification (APR=32, MPR=16, RAW=10, NC=4, clken=1 unless stated)
REQ-040 Reset, then commit ch0 inc = 0x40000000, all others 0 -> ch0 samples give sin 0, 32767, 0, -32767 and cos 32767, 0, -32767, 0, repeating.
REQ-041 Release reset -> out_valid = 0 for 3 cycles, then 1 on cycle 4 with ch_o = 0, then ch_o = 1, 2, 3, 0, ...
REQ-042 Set ch2 off = 0x20000000 and inc = 0, then commit_clr = 1 -> ch2 gives sin = cos = 23170 constantly; commit_pend stays high until the next ch = 0 cycle.
REQ-043 cfg_wr on ch1 in the apply cycle -> ch1 output unchanged until a second commit applies it.
REQ-044 Toggle clken 0/1 randomly -> the output sequence equals the clken = 1 sequence with held values; out_valid never drops.
REQ-045 Assert reset_n = 0 for one cycle with commit_pend = 1 -> all outputs 0, commit_pend = 0, no apply afterwards.
